// File: rtl/mem_stage_sram_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_sram_if
// Description : Bundle of EXE/MEM inputs, MEM/WB outputs and the 16-bit
//               external SRAM bus used by the memory pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_sram_if #(
  parameter int SRAM_AW = 18
);
  // Upstream (EXE/MEM register) side
  logic               wb_en;
  logic               mem_read_en;
  logic               mem_write_en;
  logic [31:0]        alu_res;
  logic [31:0]        value;
  logic [3:0]         dest;

  // Downstream (MemReg) side plus freeze
  logic               wb_en_out;
  logic               mem_read_en_out;
  logic [31:0]        alu_res_out;
  logic [31:0]        value_out;
  logic [3:0]         dest_out;
  logic               ready;

  // External SRAM
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_o;
  logic [15:0]        sram_dq_i;
  logic               sram_dq_oe;
  logic               sram_we_n;

  // The memory stage itself
  modport slave (
    input  wb_en, mem_read_en, mem_write_en, alu_res, value, dest, sram_dq_i,
    output wb_en_out, mem_read_en_out, alu_res_out, value_out, dest_out, ready,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
  );

  // Pipeline / SRAM environment driving the stage
  modport master (
    output wb_en, mem_read_en, mem_write_en, alu_res, value, dest, sram_dq_i,
    input  wb_en_out, mem_read_en_out, alu_res_out, value_out, dest_out, ready,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_sram.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_sram
// Description : MEM stage of the 5-stage ARM pipeline. LDR/STR are serviced as
//               two 16-bit SRAM accesses (low half, then high half), each held
//               WAIT_CYCLES clocks; ready stays low until the word is done.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_sram #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  wire logic          clk,
  input  wire logic          rst,   // asynchronous, active-low
  mem_stage_sram_if.slave    bus
);

  localparam int          CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      rd_lo_q, rd_lo_d;
  logic [15:0]      rd_hi_q, rd_hi_d;

  logic        req;
  logic        is_read;
  logic        is_write;
  logic        cnt_last;
  logic        in_access;
  logic [31:0] word;
  logic        unused_word_bits;

  // A simultaneous load/store request is serviced as a load.
  assign req       = bus.mem_read_en | bus.mem_write_en;
  assign is_read   = bus.mem_read_en;
  assign is_write  = bus.mem_write_en & ~bus.mem_read_en;
  assign cnt_last  = (cnt_q == CNT_LAST);
  assign in_access = (state_q == S_LO) || (state_q == S_HI);

  // Byte offset into the SRAM window; the byte lane bits are don't-care.
  assign word             = bus.alu_res - BASE;
  assign unused_word_bits = &{1'b0, word[31:SRAM_AW+1], word[1:0]};

  // State, wait counter and read-data capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_lo_q <= '0;
      rd_hi_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_lo_q <= rd_lo_d;
      rd_hi_q <= rd_hi_d;
    end
  end

  // Next-state logic: each half is held for WAIT_CYCLES clocks and read data
  // is sampled on the last cycle of its half.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_lo_d = rd_lo_q;
    rd_hi_d = rd_hi_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LO;
          cnt_d   = '0;
        end
      end
      S_LO: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_HI;
          if (is_read) rd_lo_d = bus.sram_dq_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HI: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (is_read) rd_hi_d = bus.sram_dq_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // SRAM bus drive; everything is parked while not mid-access.
  always_comb begin
    bus.sram_addr  = '0;
    bus.sram_dq_o  = '0;
    bus.sram_dq_oe = 1'b0;
    bus.sram_we_n  = 1'b1;
    if (in_access) begin
      bus.sram_addr = {word[SRAM_AW:2], (state_q == S_HI)};
      if (is_write) begin
        bus.sram_we_n  = 1'b0;
        bus.sram_dq_oe = 1'b1;
        bus.sram_dq_o  = (state_q == S_HI) ? bus.value[31:16] : bus.value[15:0];
      end
    end
  end

  // Freeze and MemReg outputs; a bubble goes downstream while stalled.
  always_comb begin
    bus.ready           = (state_q == S_DONE) || ((state_q == S_IDLE) && !req);
    bus.wb_en_out       = bus.wb_en & bus.ready;
    bus.mem_read_en_out = bus.mem_read_en & bus.ready;
    bus.alu_res_out     = bus.alu_res;
    bus.dest_out        = bus.dest;
    bus.value_out       = {rd_hi_q, rd_lo_q};
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_sram
// Description : Directed self-checking bench for mem_stage_sram with a small
//               behavioural SRAM attached to the 16-bit bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_sram;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [15:0] sram_mem [0:255];

  mem_stage_sram_if #(.SRAM_AW(18)) bus ();

  mem_stage_sram #(
    .BASE_ADDR  (1024),
    .WAIT_CYCLES(2),
    .SRAM_AW    (18)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: asynchronous read, write on the clock while strobed.
  assign bus.sram_dq_i = sram_mem[bus.sram_addr[7:0]];
  always @(posedge clk) begin
    if (!bus.sram_we_n) sram_mem[bus.sram_addr[7:0]] <= bus.sram_dq_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One memory op: inputs change just after an edge, so the following cycle
  // is the request cycle (k=0), k=1..4 are the two halves, k=5 is DONE.
  task automatic mem_op(input logic rd, input logic wr, input logic wb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [17:0] idx, input logic [31:0] exp_val);
    logic        w;
    logic        exp_rdy;
    logic        acc;
    logic        hi;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    @(posedge clk); #1;
    bus.mem_read_en  = rd;
    bus.mem_write_en = wr;
    bus.wb_en        = wb;
    bus.alu_res      = addr;
    bus.value        = wdata;
    bus.dest         = 4'd7;
    #1;
    w = wr & ~rd;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      exp_rdy  = (k == 5);
      acc      = (k >= 1) && (k <= 4);
      hi       = (k >= 3);
      exp_addr = acc ? (idx + {17'd0, hi}) : 18'd0;
      exp_dq   = (acc && w) ? (hi ? wdata[31:16] : wdata[15:0]) : 16'd0;
      chk($sformatf("a%0h k%0d ready", addr, k), 32'(bus.ready), 32'(exp_rdy));
      chk($sformatf("a%0h k%0d wb_en_out", addr, k), 32'(bus.wb_en_out), 32'(wb & exp_rdy));
      chk($sformatf("a%0h k%0d mem_read_en_out", addr, k), 32'(bus.mem_read_en_out), 32'(rd & exp_rdy));
      chk($sformatf("a%0h k%0d we_n", addr, k), 32'(bus.sram_we_n), 32'(!(acc && w)));
      chk($sformatf("a%0h k%0d dq_oe", addr, k), 32'(bus.sram_dq_oe), 32'(acc && w));
      chk($sformatf("a%0h k%0d sram_addr", addr, k), 32'(bus.sram_addr), 32'(exp_addr));
      if (w || !acc)
        chk($sformatf("a%0h k%0d dq_o", addr, k), 32'(bus.sram_dq_o), 32'(exp_dq));
      if (k == 5) begin
        chk($sformatf("a%0h value_out", addr), bus.value_out, exp_val);
        chk($sformatf("a%0h alu_res_out", addr), bus.alu_res_out, addr);
        chk($sformatf("a%0h dest_out", addr), 32'(bus.dest_out), 32'd7);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0000;
    rst              = 1'b0;
    bus.wb_en        = 1'b0;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.alu_res      = 32'd0;
    bus.value        = 32'd0;
    bus.dest         = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", 32'(bus.ready), 32'd1);
    chk("rst value_out", bus.value_out, 32'd0);
    chk("rst we_n", 32'(bus.sram_we_n), 32'd1);
    chk("rst dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    chk("rst sram_addr", 32'(bus.sram_addr), 32'd0);
    rst = 1'b1;

    // Non-memory instruction passes straight through
    @(posedge clk); #1;
    bus.wb_en   = 1'b1;
    bus.alu_res = 32'h55;
    bus.dest    = 4'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("alu c%0d ready", c), 32'(bus.ready), 32'd1);
      chk($sformatf("alu c%0d wb_en_out", c), 32'(bus.wb_en_out), 32'd1);
      chk($sformatf("alu c%0d mem_read_en_out", c), 32'(bus.mem_read_en_out), 32'd0);
      chk($sformatf("alu c%0d alu_res_out", c), bus.alu_res_out, 32'h55);
      chk($sformatf("alu c%0d dest_out", c), 32'(bus.dest_out), 32'd3);
      chk($sformatf("alu c%0d we_n", c), 32'(bus.sram_we_n), 32'd1);
      @(posedge clk); #1;
    end

    // STR 0xDEADBEEF @1032 -> halfwords 4/5; then LDR it back
    mem_op(1'b0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 18'd4, 32'd0);
    chk("sram[4]", 32'(sram_mem[4]), 32'h0000BEEF);
    chk("sram[5]", 32'(sram_mem[5]), 32'h0000DEAD);
    mem_op(1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 18'd4, 32'hDEADBEEF);

    // Back-to-back STR/LDR at the base of the window
    mem_op(1'b0, 1'b1, 1'b0, 32'd1024, 32'h12345678, 18'd0, 32'hDEADBEEF);
    mem_op(1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, 18'd0, 32'h12345678);

    // Reset asserted during the high half of a store
    @(posedge clk); #1;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b1;
    bus.wb_en        = 1'b0;
    bus.alu_res      = 32'd1024;
    bus.value        = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    chk("abort pre we_n", 32'(bus.sram_we_n), 32'd0);
    chk("abort pre sram_addr", 32'(bus.sram_addr), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort we_n", 32'(bus.sram_we_n), 32'd1);
    chk("abort dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    chk("abort sram_addr", 32'(bus.sram_addr), 32'd0);
    chk("abort dq_o", 32'(bus.sram_dq_o), 32'd0);
    chk("abort value_out", bus.value_out, 32'd0);
    @(posedge clk); #1;
    bus.mem_write_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("post-rst ready", 32'(bus.ready), 32'd1);
    chk("post-rst value_out", bus.value_out, 32'd0);
    @(posedge clk); #1;
    chk("post-rst idle ready", 32'(bus.ready), 32'd1);
    chk("post-rst idle we_n", 32'(bus.sram_we_n), 32'd1);

    // Read and write together: treated as a read. The aborted store only
    // updated the low halfword.
    mem_op(1'b1, 1'b1, 1'b1, 32'd1024, 32'hFFFFFFFF, 18'd0, 32'h1234F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
